// File: rtl/eth_tx_frame_reader.sv
// Pops {last, byte} words from a first-word-fall-through payload FIFO and replays them as an AXI-Stream
// frame. Frames are capped at MAX_FRAME_LEN beats and separated by IFG_CYCLES idle cycles.
module eth_tx_frame_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int IFG_CYCLES    = 12,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  err_oversize,
  output logic                  err_underrun
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0]     IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LAST  = 3'd3,
    ST_IFG   = 3'd4
  } state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic [LEN_WIDTH-1:0]  frame_len_q;
  logic [IFG_W-1:0]      ifg_cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  tuser_q;
  logic                  err_oversize_q;

  logic                  marker_s;
  logic                  out_free_s;
  logic                  rd_en_s;
  logic                  load_s;
  logic [LEN_WIDTH-1:0]  beat_cnt_inc_s;
  logic                  at_max_s;
  logic                  last_hs_s;

  // Pop/load decode; DRAIN pops without loading the output register.
  always_comb begin
    marker_s       = fifo_dout[DATA_WIDTH];
    out_free_s     = !tvalid_q || m_axis_tready;
    rd_en_s        = !fifo_empty && (((state_q == ST_SEND) && out_free_s) || (state_q == ST_DRAIN));
    load_s         = rd_en_s && (state_q == ST_SEND);
    beat_cnt_inc_s = beat_cnt_q + LEN_WIDTH'(1);
    at_max_s       = (beat_cnt_inc_s == MAX_LEN);
    last_hs_s      = tvalid_q && m_axis_tready && tlast_q;
  end

  assign fifo_rd_en    = rd_en_s;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign err_oversize  = err_oversize_q;
  assign frame_done    = last_hs_s;
  // beat_cnt_q is frozen in LAST/DRAIN, so it is the length of the frame whose tlast is handshaking.
  assign frame_len     = last_hs_s ? beat_cnt_q : frame_len_q;
  assign err_underrun  = (state_q == ST_SEND) && (beat_cnt_q != {LEN_WIDTH{1'b0}}) &&
                         out_free_s && fifo_empty;

  // Output beat register and frame sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= {LEN_WIDTH{1'b0}};
      frame_len_q    <= {LEN_WIDTH{1'b0}};
      ifg_cnt_q      <= {IFG_W{1'b0}};
      tdata_q        <= {DATA_WIDTH{1'b0}};
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tuser_q        <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      err_oversize_q <= 1'b0;
      if (last_hs_s) begin
        frame_len_q <= beat_cnt_q;
      end

      if (load_s) begin
        tvalid_q <= 1'b1;
        tdata_q  <= fifo_dout[DATA_WIDTH-1:0];
        tlast_q  <= marker_s || at_max_s;
        tuser_q  <= !marker_s && at_max_s;
      end else if (out_free_s) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ST_SEND;
            beat_cnt_q <= {LEN_WIDTH{1'b0}};
          end
        end
        ST_SEND: begin
          if (load_s) begin
            beat_cnt_q <= beat_cnt_inc_s;
            // A marker on exactly the last allowed beat is a normal frame end.
            if (marker_s) begin
              state_q <= ST_LAST;
            end else if (at_max_s) begin
              err_oversize_q <= 1'b1;
              state_q        <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_en_s && marker_s) begin
            state_q <= ST_LAST;
          end
        end
        ST_LAST: begin
          if (out_free_s) begin
            ifg_cnt_q <= {IFG_W{1'b0}};
            state_q   <= (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
          end
        end
        ST_IFG: begin
          if (ifg_cnt_q == IFG_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IFG_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
